// File: rtl/kmeans_k2n3_pkg.sv
// Shared definitions for the k=2, 3-dimension k-means controller and its
// datapath generators.
package kmeans_k2n3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_SWEEP    = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_UPDATE   = 3'd4,
    ST_WAIT_UPD = 3'd5,
    ST_FINISH   = 3'd6
  } kmeans_state_e;

  localparam int KMEANS_K    = 2;
  localparam int KMEANS_DIMS = 3;

  // subtract + square stages, then the adder tree over dims and the compare tree over k
  localparam int KMEANS_PIPELINE_LATENCY = 1 + 1 + $clog2(KMEANS_DIMS) + $clog2(KMEANS_K);

endpackage

// File: rtl/kmeans_valid_delay.sv
// Parameterized 1-bit delay line that tags pipeline outputs as belonging to a
// real sample; async active-low reset drops every in-flight tag.
module kmeans_valid_delay #(
  parameter int depth = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [depth-1:0] taps;

  generate
    if (depth == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) taps <= '0;
        else        taps <= din;
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) taps <= '0;
        else        taps <= {taps[depth-2:0], din};
      end
    end
  endgenerate

  assign dout = taps[depth-1];

endmodule

// File: rtl/kmeans_k2n3_ctrl.sv
// Iteration sequencer for the k=2, n=3 k-means datapath: sweeps the sample RAM,
// tags pipeline outputs, and requests centroid updates until convergence or cap.
module kmeans_k2n3_ctrl
  import kmeans_k2n3_pkg::*;
#(
  parameter int input_data_qty_bit_width = 8,
  parameter int input_data_qty           = 256,
  parameter int pipeline_latency         = KMEANS_PIPELINE_LATENCY,
  parameter int max_iterations           = 16,
  parameter int iter_bit_width           = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic [input_data_qty_bit_width-1:0] rd_address,
  output logic                                out_valid,
  output logic                                acc_clear,
  output logic                                update_centroids,
  input  logic                                update_done,
  input  logic                                converged,
  output logic                                busy,
  output logic                                done,
  output logic [iter_bit_width-1:0]           iteration_count
);

  localparam int drain_bit_width = $clog2(pipeline_latency + 1);

  localparam logic [input_data_qty_bit_width-1:0] last_address =
    input_data_qty_bit_width'(input_data_qty - 1);
  localparam logic [drain_bit_width-1:0] drain_last =
    drain_bit_width'(pipeline_latency - 1);
  localparam logic [iter_bit_width:0] iter_cap =
    (iter_bit_width + 1)'(max_iterations);

  kmeans_state_e              state;
  kmeans_state_e              next_state;
  logic [drain_bit_width-1:0] drain_count;
  logic                       sweep_active;
  logic [iter_bit_width:0]    iter_next;

  // One extra bit so the cap compare never sees a wrapped value.
  assign iter_next = {1'b0, iteration_count} + (iter_bit_width + 1)'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state       = state;
    acc_clear        = 1'b0;
    update_centroids = 1'b0;
    done             = 1'b0;
    busy             = 1'b1;
    sweep_active     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        acc_clear  = 1'b1;
        next_state = ST_SWEEP;
      end
      ST_SWEEP: begin
        sweep_active = 1'b1;
        if (rd_address == last_address) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_count == drain_last) next_state = ST_UPDATE;
      end
      ST_UPDATE: begin
        update_centroids = 1'b1;
        next_state       = ST_WAIT_UPD;
      end
      ST_WAIT_UPD: begin
        if (update_done) begin
          if (converged || (iter_next == iter_cap)) next_state = ST_FINISH;
          else                                      next_state = ST_CLEAR;
        end
      end
      ST_FINISH: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        next_state = ST_IDLE;
      end
    endcase
  end

  // Zeroed on the way into CLEAR so address 0 is already presented there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_address <= '0;
    end else if ((next_state == ST_CLEAR) || (next_state == ST_IDLE)) begin
      rd_address <= '0;
    end else if ((state == ST_SWEEP) && (rd_address != last_address)) begin
      rd_address <= rd_address + input_data_qty_bit_width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain_count <= '0;
    end else if ((state == ST_DRAIN) && (drain_count != drain_last)) begin
      drain_count <= drain_count + drain_bit_width'(1);
    end else begin
      drain_count <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iteration_count <= '0;
    end else if ((state == ST_IDLE) && start) begin
      iteration_count <= '0;
    end else if ((state == ST_WAIT_UPD) && update_done) begin
      iteration_count <= iter_next[iter_bit_width-1:0];
    end
  end

  kmeans_valid_delay #(
    .depth(pipeline_latency)
  ) u_valid_delay (
    .clk  (clk),
    .rst_n(rst),
    .din  (sweep_active),
    .dout (out_valid)
  );

endmodule

// File: tb/tb_kmeans_k2n3_ctrl.sv
// Self-checking bench for kmeans_k2n3_ctrl: expected outputs come from the
// per-iteration cycle timeline (offset from the acc_clear cycle).
module tb_kmeans_k2n3_ctrl;

  localparam int N    = 8;
  localparam int L    = 5;
  localparam int MAXI = 3;
  localparam int AW   = 8;
  localparam int IW   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          update_done = 1'b0;
  logic          converged = 1'b0;
  logic [AW-1:0] rd_address;
  logic          out_valid;
  logic          acc_clear;
  logic          update_centroids;
  logic          busy;
  logic          done;
  logic [IW-1:0] iteration_count;

  int checks = 0;
  int errors = 0;
  int model_iter = 0;

  always #5 clk = ~clk;

  kmeans_k2n3_ctrl #(
    .input_data_qty_bit_width(AW),
    .input_data_qty          (N),
    .pipeline_latency        (L),
    .max_iterations          (MAXI),
    .iter_bit_width          (IW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .rd_address      (rd_address),
    .out_valid       (out_valid),
    .acc_clear       (acc_clear),
    .update_centroids(update_centroids),
    .update_done     (update_done),
    .converged       (converged),
    .busy            (busy),
    .done            (done),
    .iteration_count (iteration_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: observed %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  // Inputs are already driven for this cycle; compare at the falling edge, then advance.
  task automatic step_check(input int e_addr, input bit e_valid, input bit e_clr, input bit e_upd,
                            input bit e_busy, input bit e_done, input int e_iter);
    @(negedge clk);
    checkOutput("rd_address", 32'(rd_address), e_addr);
    checkOutput("out_valid", 32'(out_valid), 32'(e_valid));
    checkOutput("acc_clear", 32'(acc_clear), 32'(e_clr));
    checkOutput("update_centroids", 32'(update_centroids), 32'(e_upd));
    checkOutput("busy", 32'(busy), 32'(e_busy));
    checkOutput("done", 32'(done), 32'(e_done));
    checkOutput("iteration_count", 32'(iteration_count), e_iter);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit spur, input bit hold);
    if (spur) begin
      start       = 1'($urandom_range(0, 1));
      update_done = 1'($urandom_range(0, 1));
      converged   = 1'($urandom_range(0, 1));
    end else begin
      start       = hold;
      update_done = 1'b0;
      converged   = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start       = 1'b0;
      update_done = 1'($urandom_range(0, 1));
      converged   = 1'($urandom_range(0, 1));
      step_check(0, 0, 0, 0, 0, 0, model_iter);
    end
    update_done = 1'b0;
    converged   = 1'b0;
  endtask

  // k=0 clear, k=1..N sweep, k=N+1..N+L drain, k=N+L+1 update request.
  task automatic sweep_iter(input int it, input bit spur, input bit hold, input int last_k);
    for (int k = 0; k <= last_k; k++) begin
      int e_addr;
      applyStimulus(spur, hold);
      e_addr = (k == 0) ? 0 : ((k <= N) ? k - 1 : N - 1);
      step_check(e_addr, (k >= L + 1) && (k <= L + N), k == 0, k == N + L + 1, 1, 0, it);
    end
  endtask

  task automatic wait_update(input int it, input int dly, input bit cv, input bit hold);
    for (int d = 0; d < dly; d++) begin
      start       = hold | 1'($urandom_range(0, 1));
      update_done = 1'b0;
      converged   = 1'($urandom_range(0, 1));
      step_check(N - 1, 0, 0, 0, 1, 0, it);
    end
    start       = hold;
    update_done = 1'b1;
    converged   = cv;
    step_check(N - 1, 0, 0, 0, 1, 0, it);
    update_done = 1'b0;
    converged   = 1'b0;
  endtask

  task automatic do_run(input bit spur, input int fixed_delay, input int conv_mode, input bit hold);
    int it;
    bit fin;
    int dly;
    bit cv;
    start       = 1'b1;
    update_done = 1'b0;
    converged   = 1'b0;
    step_check(0, 0, 0, 0, 0, 0, model_iter);
    it  = 0;
    fin = 1'b0;
    while (!fin) begin
      sweep_iter(it, spur, hold, N + L + 1);
      dly = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 6));
      cv  = (conv_mode >= 0) ? conv_mode[0] : ($urandom_range(0, 2) == 0);
      wait_update(it, dly, cv, hold);
      it++;
      fin = cv || (it == MAXI);
    end
    start = hold;
    step_check(N - 1, 0, 0, 0, 1, 1, it);
    model_iter = it;
  endtask

  task automatic reset_mid_sweep();
    start = 1'b1;
    step_check(0, 0, 0, 0, 0, 0, model_iter);
    start = 1'b0;
    sweep_iter(0, 0, 0, N + L + 1);
    wait_update(0, 1, 0, 0);
    sweep_iter(1, 0, 0, 4);
    checkOutput("pre_reset_addr", 32'(rd_address), 4);
    checkOutput("pre_reset_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    checkOutput("rst_rd_address", 32'(rd_address), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_iteration_count", 32'(iteration_count), 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_iter = 0;
    idle_cycles(3);
    do_run(0, 1, 1, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst   = 1'b0;
    start = 1'b1;
    step_check(0, 0, 0, 0, 0, 0, 0);
    step_check(0, 0, 0, 0, 0, 0, 0);
    rst   = 1'b1;
    idle_cycles(3);

    $display("[TB] single converged iteration");
    do_run(0, 1, 1, 0);
    idle_cycles(2);

    $display("[TB] iteration cap");
    do_run(0, 1, 0, 0);
    idle_cycles(2);

    $display("[TB] slow update unit");
    do_run(0, 20, 1, 0);
    idle_cycles(1);

    $display("[TB] spurious inputs");
    do_run(1, 1, 1, 0);
    idle_cycles(1);

    $display("[TB] reset mid-sweep");
    reset_mid_sweep();
    idle_cycles(1);

    $display("[TB] back-to-back runs");
    do_run(0, 2, 0, 1);
    do_run(0, 1, 1, 0);
    idle_cycles(1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 10; r++) begin
      bit spur;
      bit hold;
      spur = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      if (!hold) idle_cycles(int'($urandom_range(0, 3)));
      do_run(spur, -1, -1, hold);
    end
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
